// File: rtl/local_memory_controller_pkg.sv
// Shared types and constants for the local memory controller.
package local_memory_controller_pkg;

  // Per-port FSM: a request is issued from idle and reported complete for one cycle.
  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_DONE = 1'b1
  } state_e;

  // Identity of the port that won the last same-bank collision.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Read data presented whenever a port has nothing valid to return.
  localparam logic [31:0] READ_IDLE_VALUE = '1;

endpackage

// File: rtl/local_memory_bank_decode.sv
// Splits a 24-bit byte address into range flag, bank index and per-macro word address.
module local_memory_bank_decode #(
  parameter int unsigned SramCount     = 4,
  parameter int unsigned SramAddrWidth = 9,
  parameter int unsigned BankW         = 2
) (
  input  logic [23:0]              address_i,
  output logic                     in_range_o,
  output logic [BankW-1:0]         bank_o,
  output logic [SramAddrWidth-1:0] word_o
);

  localparam int unsigned BankBits = $clog2(SramCount);
  localparam int unsigned TopBit   = SramAddrWidth + 2 + BankBits;

  // Byte offset bits [1:0] are ignored; anything above the bank field is out of range.
  always_comb begin
    word_o     = address_i[SramAddrWidth+1:2];
    bank_o     = '0;
    if (SramCount > 1) begin
      bank_o = BankW'(address_i >> (SramAddrWidth + 2));
    end
    in_range_o = ((address_i >> TopBit) == 24'd0);
  end

endmodule

// File: rtl/local_memory_controller.sv
// Two-port arbiter onto SRAM_COUNT single-port SRAM macros; ports on different banks proceed
// in parallel, same-bank collisions alternate between the ports.
module local_memory_controller
  import local_memory_controller_pkg::*;
#(
  parameter int unsigned SRAM_COUNT      = 4,
  parameter int unsigned SRAM_ADDR_WIDTH = 9
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_n_i,
  input  logic                                  localMemoryEnable,
  input  logic                                  localMemoryWriteEnable,
  input  logic [23:0]                           localMemoryAddress,
  input  logic [3:0]                            localMemoryByteSelect,
  input  logic [31:0]                           localMemoryDataWrite,
  output logic [31:0]                           localMemoryDataRead,
  output logic                                  localMemoryBusy,
  input  logic                                  coreMemoryEnable,
  input  logic                                  coreMemoryWriteEnable,
  input  logic [23:0]                           coreMemoryAddress,
  input  logic [3:0]                            coreMemoryByteSelect,
  input  logic [31:0]                           coreMemoryDataWrite,
  output logic [31:0]                           coreMemoryDataRead,
  output logic                                  coreMemoryBusy,
  output logic [SRAM_COUNT-1:0]                 sram_csb,
  output logic [SRAM_COUNT-1:0]                 sram_web,
  output logic [4*SRAM_COUNT-1:0]               sram_wmask,
  output logic [SRAM_ADDR_WIDTH*SRAM_COUNT-1:0] sram_addr,
  output logic [32*SRAM_COUNT-1:0]              sram_din,
  input  logic [32*SRAM_COUNT-1:0]              sram_dout
);

  localparam int unsigned BankW = (SRAM_COUNT > 1) ? $clog2(SRAM_COUNT) : 1;

  logic                       a_in_range, b_in_range;
  logic [BankW-1:0]           a_bank, b_bank;
  logic [SRAM_ADDR_WIDTH-1:0] a_word, b_word;

  local_memory_bank_decode #(
    .SramCount    (SRAM_COUNT),
    .SramAddrWidth(SRAM_ADDR_WIDTH),
    .BankW        (BankW)
  ) u_decode_a (
    .address_i (localMemoryAddress),
    .in_range_o(a_in_range),
    .bank_o    (a_bank),
    .word_o    (a_word)
  );

  local_memory_bank_decode #(
    .SramCount    (SRAM_COUNT),
    .SramAddrWidth(SRAM_ADDR_WIDTH),
    .BankW        (BankW)
  ) u_decode_b (
    .address_i (coreMemoryAddress),
    .in_range_o(b_in_range),
    .bank_o    (b_bank),
    .word_o    (b_word)
  );

  state_e           a_state_q, a_state_d, b_state_q, b_state_d;
  logic             last_winner_q;
  logic [BankW-1:0] a_bank_q, b_bank_q;
  logic             a_rd_q, b_rd_q;

  logic a_req, b_req, a_hit, b_hit, collide, grant_a, grant_b, a_issue, b_issue;

  // Arbitration: only a same-bank collision consults the fairness bit. Nothing is issued while
  // reset is held so the macros stay idle during reset.
  always_comb begin
    a_req   = wb_rst_n_i && localMemoryEnable && (a_state_q == STATE_IDLE);
    b_req   = wb_rst_n_i && coreMemoryEnable && (b_state_q == STATE_IDLE);
    a_hit   = a_req && a_in_range;
    b_hit   = b_req && b_in_range;
    collide = a_hit && b_hit && (a_bank == b_bank);
    grant_a = a_hit && (!collide || (last_winner_q == PORT_B));
    grant_b = b_hit && (!collide || (last_winner_q == PORT_A));
    // Out-of-range requests complete without touching a macro.
    a_issue = a_req && (!a_in_range || grant_a);
    b_issue = b_req && (!b_in_range || grant_b);
  end

  // State register for both port FSMs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      a_state_q <= STATE_IDLE;
      b_state_q <= STATE_IDLE;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
    end
  end

  // Next state: issue moves to DONE, DONE always returns to IDLE after one cycle.
  always_comb begin
    a_state_d = a_state_q;
    b_state_d = b_state_q;
    unique case (a_state_q)
      STATE_IDLE: if (a_issue) a_state_d = STATE_DONE;
      STATE_DONE: a_state_d = STATE_IDLE;
    endcase
    unique case (b_state_q)
      STATE_IDLE: if (b_issue) b_state_d = STATE_DONE;
      STATE_DONE: b_state_d = STATE_IDLE;
    endcase
  end

  // Remember which bank each port read from and keep the collision fairness bit.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      last_winner_q <= PORT_A;
      a_bank_q      <= '0;
      b_bank_q      <= '0;
      a_rd_q        <= 1'b0;
      b_rd_q        <= 1'b0;
    end else begin
      if (a_issue) begin
        a_bank_q <= a_bank;
        a_rd_q   <= a_in_range && !localMemoryWriteEnable;
      end
      if (b_issue) begin
        b_bank_q <= b_bank;
        b_rd_q   <= b_in_range && !coreMemoryWriteEnable;
      end
      if (collide) last_winner_q <= grant_b ? PORT_B : PORT_A;
    end
  end

  // Port outputs: busy until DONE, read data only for an in-range read in DONE.
  always_comb begin
    localMemoryBusy     = localMemoryEnable && (a_state_q != STATE_DONE);
    coreMemoryBusy      = coreMemoryEnable && (b_state_q != STATE_DONE);
    localMemoryDataRead = READ_IDLE_VALUE;
    coreMemoryDataRead  = READ_IDLE_VALUE;
    if ((a_state_q == STATE_DONE) && a_rd_q) localMemoryDataRead = sram_dout[32*a_bank_q +: 32];
    if ((b_state_q == STATE_DONE) && b_rd_q) coreMemoryDataRead = sram_dout[32*b_bank_q +: 32];
  end

  // Macro input muxes; grants never target the same bank, so the order below is arbitrary.
  always_comb begin
    sram_csb   = '1;
    sram_web   = '1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    for (int unsigned i = 0; i < SRAM_COUNT; i++) begin
      if (grant_b && (b_bank == BankW'(i))) begin
        sram_csb[i]                                    = 1'b0;
        sram_web[i]                                    = !coreMemoryWriteEnable;
        sram_wmask[4*i +: 4]                           = coreMemoryByteSelect;
        sram_addr[SRAM_ADDR_WIDTH*i +: SRAM_ADDR_WIDTH] = b_word;
        sram_din[32*i +: 32]                           = coreMemoryDataWrite;
      end else if (grant_a && (a_bank == BankW'(i))) begin
        sram_csb[i]                                    = 1'b0;
        sram_web[i]                                    = !localMemoryWriteEnable;
        sram_wmask[4*i +: 4]                           = localMemoryByteSelect;
        sram_addr[SRAM_ADDR_WIDTH*i +: SRAM_ADDR_WIDTH] = a_word;
        sram_din[32*i +: 32]                           = localMemoryDataWrite;
      end
    end
  end

endmodule

// File: tb/tb_local_memory_controller.sv
// Bench for local_memory_controller: directed scenarios plus randomized dual-port traffic
// checked against a flat word-array reference and a latency/fairness model.
module tb_local_memory_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_en, a_we, b_en, b_we;
  logic [23:0]  a_addr, b_addr;
  logic [3:0]   a_sel, b_sel;
  logic [31:0]  a_wd, b_wd, a_rd, b_rd;
  logic         a_busy, b_busy;
  logic [3:0]   sram_csb, sram_web;
  logic [15:0]  sram_wmask;
  logic [35:0]  sram_addr;
  logic [127:0] sram_din, sram_dout;

  int n_cmp = 0;
  int n_err = 0;
  int tb_lw = 0;  // 0: A won the last collision (reset value), 1: B

  always #5 clk = ~clk;

  local_memory_controller #(.SRAM_COUNT(4), .SRAM_ADDR_WIDTH(9)) dut (
    .wb_clk_i              (clk),
    .wb_rst_n_i            (rst_n),
    .localMemoryEnable     (a_en),
    .localMemoryWriteEnable(a_we),
    .localMemoryAddress    (a_addr),
    .localMemoryByteSelect (a_sel),
    .localMemoryDataWrite  (a_wd),
    .localMemoryDataRead   (a_rd),
    .localMemoryBusy       (a_busy),
    .coreMemoryEnable      (b_en),
    .coreMemoryWriteEnable (b_we),
    .coreMemoryAddress     (b_addr),
    .coreMemoryByteSelect  (b_sel),
    .coreMemoryDataWrite   (b_wd),
    .coreMemoryDataRead    (b_rd),
    .coreMemoryBusy        (b_busy),
    .sram_csb              (sram_csb),
    .sram_web              (sram_web),
    .sram_wmask            (sram_wmask),
    .sram_addr             (sram_addr),
    .sram_din              (sram_din),
    .sram_dout             (sram_dout)
  );

  function automatic logic [31:0] seed_word(int idx);
    return 32'h5A5A_0F0F ^ (idx * 32'h0001_0193);
  endfunction

  // SRAM macro models: registered read output that holds between reads.
  logic [31:0] sram_mem [4][512];
  logic [31:0] sram_q [4];
  bit          sram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int i = 0; i < 4; i++)
        for (int w = 0; w < 512; w++) sram_mem[i][w] <= seed_word(i * 512 + w);
      sram_init_done <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!sram_csb[i]) begin
          if (!sram_web[i]) begin
            for (int k = 0; k < 4; k++)
              if (sram_wmask[4*i+k])
                sram_mem[i][sram_addr[9*i +: 9]][8*k +: 8] <= sram_din[32*i+8*k +: 8];
          end else begin
            sram_q[i] <= sram_mem[i][sram_addr[9*i +: 9]];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) sram_dout[32*i +: 32] = sram_q[i];
  end

  // Reference: flat 2048-word memory indexed by byte address / 4.
  logic [31:0] ref_mem [2048];

  function automatic bit ref_in_range(logic [23:0] a);
    return a < 24'h2000;
  endfunction

  function automatic int ref_bank(logic [23:0] a);
    return (int'(a) / 2048) % 4;
  endfunction

  // Applies an access to the reference and returns the data the port must present.
  function automatic logic [31:0] ref_access(logic we, logic [23:0] a, logic [3:0] sel,
                                             logic [31:0] d);
    int idx;
    if (!ref_in_range(a)) return 32'hFFFF_FFFF;
    idx = int'(a) / 4;
    if (!we) return ref_mem[idx];
    for (int k = 0; k < 4; k++) if (sel[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic en, logic we, logic [23:0] ad, logic [3:0] sel, logic [31:0] d);
    a_en = en; a_we = we; a_addr = ad; a_sel = sel; a_wd = d;
  endtask

  task automatic drive_b(logic en, logic we, logic [23:0] ad, logic [3:0] sel, logic [31:0] d);
    b_en = en; b_we = we; b_addr = ad; b_sel = sel; b_wd = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    tick(); tick();
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
    n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
    n_cmp++; if (a_rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_a_rd: got %h want ffffffff", a_rd); end
    n_cmp++; if (b_rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_b_rd: got %h want ffffffff", b_rd); end
    n_cmp++;
    if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !== {8'hFF, 180'd0}) begin
      n_err++;
      $display("FAIL reset_macro_idle: csb %h web %h wmask %h addr %h din %h", sram_csb, sram_web,
               sram_wmask, sram_addr, sram_din);
    end
    drive_a(1, 0, 24'h000100, 4'hF, 0);
    drive_b(1, 0, 24'h000800, 4'hF, 0);
    #1;
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy_follows_en: got %b want 1", a_busy); end
    n_cmp++; if (sram_csb !== 4'hF) begin n_err++; $display("FAIL reset_no_select: got %h want f", sram_csb); end
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tb_lw = 0;
    tick();
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    drive_a(1, 1, 24'h000104, 4'hF, 32'hDEAD_BEEF);
    e = ref_access(1'b1, 24'h000104, 4'hF, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (sram_csb !== 4'b1110) begin n_err++; $display("FAIL wr_csb: got %b want 1110", sram_csb); end
    n_cmp++;
    if ({sram_web[0], sram_addr[8:0], sram_wmask[3:0]} !== {1'b0, 9'h041, 4'hF}) begin
      n_err++;
      $display("FAIL wr_macro: web %b addr %h wmask %h want 0 041 f", sram_web[0], sram_addr[8:0],
               sram_wmask[3:0]);
    end
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_issue: got %b want 1", a_busy); end
    tick();
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_done: got %b want 0", a_busy); end
    n_cmp++; if (a_rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wr_rd_value: got %h want ffffffff", a_rd); end
    drive_a(0, 0, 0, 0, 0);
    tick();
    drive_a(1, 0, 24'h000104, 4'hF, 0);
    #1;
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_issue: got %b want 1", a_busy); end
    tick();
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_done: got %b want 0", a_busy); end
    n_cmp++; if (a_rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", a_rd); end
    drive_a(0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (a_rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rd_after_done: got %h want ffffffff", a_rd); end
  endtask

  task automatic test_byte_write();
    logic [31:0] e;
    drive_a(1, 1, 24'h000208, 4'hF, 32'h1122_3344);
    e = ref_access(1'b1, 24'h000208, 4'hF, 32'h1122_3344);
    tick(); drive_a(0, 0, 0, 0, 0); tick();
    drive_a(1, 1, 24'h000209, 4'b0010, 32'h0000_AA00);
    e = ref_access(1'b1, 24'h000209, 4'b0010, 32'h0000_AA00);
    tick(); drive_a(0, 0, 0, 0, 0); tick();
    drive_a(1, 0, 24'h00020A, 4'hF, 0);
    tick();
    n_cmp++; if (a_rd !== 32'h1122_AA44) begin n_err++; $display("FAIL byte_write: got %h want 1122aa44", a_rd); end
    drive_a(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_parallel();
    logic [31:0] ea, eb;
    drive_a(1, 0, 24'h000804, 4'hF, 0);
    drive_b(1, 0, 24'h001008, 4'hF, 0);
    ea = ref_access(1'b0, 24'h000804, 4'hF, 0);
    eb = ref_access(1'b0, 24'h001008, 4'hF, 0);
    #1;
    n_cmp++; if (sram_csb !== 4'b1001) begin n_err++; $display("FAIL par_csb: got %b want 1001", sram_csb); end
    tick();
    n_cmp++; if ({a_busy, b_busy} !== 2'b00) begin n_err++; $display("FAIL par_busy: got %b want 00", {a_busy, b_busy}); end
    n_cmp++; if (a_rd !== ea) begin n_err++; $display("FAIL par_a_data: got %h want %h", a_rd, ea); end
    n_cmp++; if (b_rd !== eb) begin n_err++; $display("FAIL par_b_data: got %h want %h", b_rd, eb); end
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_collision();
    logic [31:0] ea, eb;
    for (int r = 0; r < 2; r++) begin
      drive_a(1, 0, 24'h001810, 4'hF, 0);
      drive_b(1, 0, 24'h001804, 4'hF, 0);
      ea = ref_access(1'b0, 24'h001810, 4'hF, 0);
      eb = ref_access(1'b0, 24'h001804, 4'hF, 0);
      tick();
      if (r == 0) begin
        n_cmp++; if ({a_busy, b_busy} !== 2'b10) begin n_err++; $display("FAIL coll0_first: got ab=%b want 10", {a_busy, b_busy}); end
        n_cmp++; if (b_rd !== eb) begin n_err++; $display("FAIL coll0_b_data: got %h want %h", b_rd, eb); end
        drive_b(0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL coll0_second: got %b want 0", a_busy); end
        n_cmp++; if (a_rd !== ea) begin n_err++; $display("FAIL coll0_a_data: got %h want %h", a_rd, ea); end
      end else begin
        n_cmp++; if ({a_busy, b_busy} !== 2'b01) begin n_err++; $display("FAIL coll1_first: got ab=%b want 01", {a_busy, b_busy}); end
        n_cmp++; if (a_rd !== ea) begin n_err++; $display("FAIL coll1_a_data: got %h want %h", a_rd, ea); end
        drive_a(0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL coll1_second: got %b want 0", b_busy); end
        n_cmp++; if (b_rd !== eb) begin n_err++; $display("FAIL coll1_b_data: got %h want %h", b_rd, eb); end
      end
      drive_a(0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0);
      tick();
    end
    tb_lw = 0;
  endtask

  task automatic test_out_of_range();
    for (int w = 0; w < 2; w++) begin
      drive_a(1, w[0], 24'h7FFFFC, 4'hF, 32'h0BAD_F00D);
      #1;
      n_cmp++; if (sram_csb !== 4'hF) begin n_err++; $display("FAIL oor_csb: got %h want f", sram_csb); end
      tick();
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL oor_busy: got %b want 0", a_busy); end
      n_cmp++; if (a_rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL oor_data: got %h want ffffffff", a_rd); end
      drive_a(0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset_in_done();
    logic [31:0] ea;
    drive_a(1, 0, 24'h000C0C, 4'hF, 0);
    tick();
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rid_done: got %b want 0", a_busy); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL rid_busy: got %b want 1", a_busy); end
    n_cmp++; if (a_rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rid_data: got %h want ffffffff", a_rd); end
    n_cmp++; if (sram_csb !== 4'hF) begin n_err++; $display("FAIL rid_csb: got %h want f", sram_csb); end
    rst_n = 1'b1;
    tb_lw = 0;
    ea = ref_access(1'b0, 24'h000C0C, 4'hF, 0);
    #1;
    n_cmp++; if (sram_csb !== 4'b1101) begin n_err++; $display("FAIL rid_reissue_csb: got %b want 1101", sram_csb); end
    tick();
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rid_reissue_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_rd !== ea) begin n_err++; $display("FAIL rid_reissue_data: got %h want %h", a_rd, ea); end
    drive_a(0, 0, 0, 0, 0);
    tick();
  endtask

  function automatic logic [23:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 24'h002000 + 24'($urandom_range(0, 24'hFFDFFF));
    return 24'($urandom_range(0, 3) * 2048 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic        ea_en, eb_en, wa, wb, coll, b_first, a_open, b_open;
    logic [23:0] aa, ab;
    logic [3:0]  sa, sb;
    logic [31:0] da, db, xa, xb;
    int          lat_a, lat_b;
    for (int it = 0; it < 250; it++) begin
      ea_en = ($urandom_range(0, 3) != 0);
      eb_en = ($urandom_range(0, 3) != 0);
      wa = $urandom_range(0, 1); wb = $urandom_range(0, 1);
      aa = rand_addr(); ab = rand_addr();
      sa = 4'($urandom_range(0, 15)); sb = 4'($urandom_range(0, 15));
      da = $urandom; db = $urandom;
      coll = ea_en && eb_en && ref_in_range(aa) && ref_in_range(ab) && (ref_bank(aa) == ref_bank(ab));
      b_first = (tb_lw == 0);
      if (coll) tb_lw = b_first ? 1 : 0;
      lat_a = (coll && b_first) ? 2 : 1;
      lat_b = (coll && !b_first) ? 2 : 1;
      xa = 0; xb = 0;
      if (coll && !b_first) begin
        xa = ref_access(wa, aa, sa, da);
        xb = ref_access(wb, ab, sb, db);
      end else begin
        if (eb_en) xb = ref_access(wb, ab, sb, db);
        if (ea_en) xa = ref_access(wa, aa, sa, da);
      end
      drive_a(ea_en, wa, aa, sa, da);
      drive_b(eb_en, wb, ab, sb, db);
      a_open = ea_en; b_open = eb_en;
      for (int c = 1; c <= 2; c++) begin
        tick();
        if (a_open) begin
          n_cmp++;
          if (a_busy !== (c < lat_a)) begin
            n_err++;
            $display("FAIL rnd_a_busy it%0d c%0d: got %b want %b", it, c, a_busy, c < lat_a);
          end
          if (c == lat_a) begin
            n_cmp++;
            if (a_rd !== xa) begin n_err++; $display("FAIL rnd_a_data it%0d: got %h want %h", it, a_rd, xa); end
            drive_a(0, 0, 0, 0, 0);
            a_open = 1'b0;
          end
        end
        if (b_open) begin
          n_cmp++;
          if (b_busy !== (c < lat_b)) begin
            n_err++;
            $display("FAIL rnd_b_busy it%0d c%0d: got %b want %b", it, c, b_busy, c < lat_b);
          end
          if (c == lat_b) begin
            n_cmp++;
            if (b_rd !== xb) begin n_err++; $display("FAIL rnd_b_data it%0d: got %h want %h", it, b_rd, xb); end
            drive_b(0, 0, 0, 0, 0);
            b_open = 1'b0;
          end
        end
      end
      drive_a(0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = seed_word(i);
    test_reset();
    test_write_read();
    test_byte_write();
    test_parallel();
    test_collision();
    test_out_of_range();
    test_reset_in_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
